keypad_digit_collector: RTL and testbench

//  Upstream entry stage for the six-digit lock controller. Collects BCD key

---
 rtl/keypad_digit_collector_pkg.sv | 25 ++
 rtl/keypad_digit_collector_timer.sv | 30 +++
 rtl/keypad_digit_collector.sv | 193 +++++++++++++++++++
 tb/tb_keypad_digit_collector.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/keypad_digit_collector_pkg.sv
// Shared key codes, FSM state encoding and small helpers for the keypad
// digit collector and its idle timer.
package keypad_digit_collector_pkg;

  localparam logic [3:0] KEY_BKSP = 4'hA;
  localparam logic [3:0] KEY_ENT  = 4'hB;
  localparam logic [3:0] KEY_CLR  = 4'hC;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ENTRY  = 2'd1,
    ST_FULL   = 2'd2,
    ST_SUBMIT = 2'd3
  } state_t;

  function automatic logic is_digit(input logic [3:0] code);
    return code <= 4'd9;
  endfunction

  // Codes D-F are neither digits nor commands; they never count as a key stroke.
  function automatic logic is_known_key(input logic [3:0] code);
    return code <= KEY_CLR;
  endfunction

endpackage

// File: rtl/keypad_digit_collector_timer.sv
// Inactivity timer: cleared by any accepted key, counts while enabled and
// raises a combinational terminal-count flag on its last cycle.
module entry_idle_timer #(
  parameter int          TW          = 26,
  parameter int unsigned TIMEOUT_CYC = 50000000
) (
  input  logic clk,
  input  logic clr_n,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam logic [TW-1:0] TERM = TW'(TIMEOUT_CYC - 1);

  logic [TW-1:0] count_reg;

  assign expired = enable && (count_reg == TERM);

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      count_reg <= '0;
    end else if (clear || !enable || expired) begin
      count_reg <= '0;
    end else begin
      count_reg <= count_reg + TW'(1);
    end
  end

endmodule

// File: rtl/keypad_digit_collector.sv
// Collects BCD key strokes into a six-digit register file feeding the lock,
// with backspace, clear, enter and an inactivity timeout.
module keypad_digit_collector
  import keypad_digit_collector_pkg::*;
#(
  parameter int          NDIG        = 6,
  parameter int unsigned TIMEOUT_CYC = 50000000,
  parameter int          TW          = 26
) (
  input  logic       clk,
  input  logic       clr_n,
  input  logic       key_valid,
  input  logic [3:0] key_code,
  output logic [3:0] dig1,
  output logic [3:0] dig2,
  output logic [3:0] dig3,
  output logic [3:0] dig4,
  output logic [3:0] dig5,
  output logic [3:0] dig6,
  output logic [2:0] digit_cnt,
  output logic       full,
  output logic       submit,
  output logic       err,
  output logic       timeout
);

  localparam logic [2:0] FULL_CNT = 3'(NDIG);
  localparam logic [2:0] LAST_IDX = 3'(NDIG - 1);

  state_t     state_reg, state_next;
  logic [3:0] dig_reg  [NDIG];
  logic [3:0] dig_next [NDIG];
  logic [2:0] cnt_reg, cnt_next;
  logic       full_reg;
  logic       submit_reg, submit_next;
  logic       err_reg, err_next;
  logic       timeout_reg, timeout_next;
  logic       clear_all;
  logic       key_acc;
  logic       timer_en;
  logic       timer_expired;

  // Keys arriving during the SUBMIT hold cycle are dropped outright.
  assign key_acc  = key_valid && (state_reg != ST_SUBMIT) && is_known_key(key_code);
  assign timer_en = (state_reg == ST_ENTRY) || (state_reg == ST_FULL);

  entry_idle_timer #(
    .TW          (TW),
    .TIMEOUT_CYC (TIMEOUT_CYC)
  ) u_idle_timer (
    .clk     (clk),
    .clr_n   (clr_n),
    .clear   (key_acc),
    .enable  (timer_en),
    .expired (timer_expired)
  );

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      state_reg <= ST_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next   = state_reg;
    cnt_next     = cnt_reg;
    submit_next  = 1'b0;
    err_next     = 1'b0;
    timeout_next = 1'b0;
    clear_all    = 1'b0;
    for (int i = 0; i < NDIG; i++) begin
      dig_next[i] = dig_reg[i];
    end

    case (state_reg)
      ST_IDLE: begin
        if (key_acc) begin
          if (is_digit(key_code)) begin
            dig_next[0] = key_code;
            cnt_next    = 3'd1;
            state_next  = ST_ENTRY;
          end else if (key_code == KEY_ENT) begin
            err_next = 1'b1;
          end
        end
      end

      ST_ENTRY: begin
        if (key_acc) begin
          if (is_digit(key_code)) begin
            dig_next[cnt_reg] = key_code;
            cnt_next          = cnt_reg + 3'd1;
            if (cnt_reg == LAST_IDX) begin
              state_next = ST_FULL;
            end
          end else if (key_code == KEY_BKSP) begin
            dig_next[cnt_reg - 3'd1] = 4'd0;
            cnt_next                 = cnt_reg - 3'd1;
            if (cnt_reg == 3'd1) begin
              state_next = ST_IDLE;
            end
          end else if (key_code == KEY_CLR) begin
            clear_all  = 1'b1;
            state_next = ST_IDLE;
          end else begin
            err_next = 1'b1;
          end
        end else if (timer_expired) begin
          clear_all    = 1'b1;
          timeout_next = 1'b1;
          state_next   = ST_IDLE;
        end
      end

      ST_FULL: begin
        if (key_acc) begin
          if (is_digit(key_code)) begin
            err_next = 1'b1;
          end else if (key_code == KEY_BKSP) begin
            dig_next[LAST_IDX] = 4'd0;
            cnt_next           = LAST_IDX;
            state_next         = ST_ENTRY;
          end else if (key_code == KEY_CLR) begin
            clear_all  = 1'b1;
            state_next = ST_IDLE;
          end else begin
            submit_next = 1'b1;
            state_next  = ST_SUBMIT;
          end
        end else if (timer_expired) begin
          clear_all    = 1'b1;
          timeout_next = 1'b1;
          state_next   = ST_IDLE;
        end
      end

      // Digits stayed visible while submit was high; wipe them now.
      ST_SUBMIT: begin
        clear_all  = 1'b1;
        state_next = ST_IDLE;
      end

      default: begin
        clear_all  = 1'b1;
        state_next = ST_IDLE;
      end
    endcase

    if (clear_all) begin
      cnt_next = 3'd0;
      for (int i = 0; i < NDIG; i++) begin
        dig_next[i] = 4'd0;
      end
    end
  end

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      cnt_reg     <= 3'd0;
      full_reg    <= 1'b0;
      submit_reg  <= 1'b0;
      err_reg     <= 1'b0;
      timeout_reg <= 1'b0;
      for (int i = 0; i < NDIG; i++) begin
        dig_reg[i] <= 4'd0;
      end
    end else begin
      cnt_reg     <= cnt_next;
      full_reg    <= (cnt_next == FULL_CNT);
      submit_reg  <= submit_next;
      err_reg     <= err_next;
      timeout_reg <= timeout_next;
      for (int i = 0; i < NDIG; i++) begin
        dig_reg[i] <= dig_next[i];
      end
    end
  end

  assign dig1      = dig_reg[0];
  assign dig2      = dig_reg[1];
  assign dig3      = dig_reg[2];
  assign dig4      = dig_reg[3];
  assign dig5      = dig_reg[4];
  assign dig6      = dig_reg[5];
  assign digit_cnt = cnt_reg;
  assign full      = full_reg;
  assign submit    = submit_reg;
  assign err       = err_reg;
  assign timeout   = timeout_reg;

endmodule

// File: tb/tb_keypad_digit_collector.sv
// Directed and randomized bench for keypad_digit_collector against a
// queue-based model of the code-entry rules.
module tb_keypad_digit_collector;

  localparam int TMO = 16;

  logic       clk;
  logic       clr_n;
  logic       key_valid;
  logic [3:0] key_code;
  logic [3:0] dig1, dig2, dig3, dig4, dig5, dig6;
  logic [2:0] digit_cnt;
  logic       full, submit, err, timeout;

  int checks = 0;
  int errors = 0;

  // Reference model state: digits held in entry order.
  int q[$];
  bit pending;
  int idle;
  bit exp_sub, exp_err, exp_to;

  keypad_digit_collector #(
    .NDIG        (6),
    .TIMEOUT_CYC (TMO),
    .TW          (5)
  ) dut (
    .clk       (clk),
    .clr_n     (clr_n),
    .key_valid (key_valid),
    .key_code  (key_code),
    .dig1      (dig1),
    .dig2      (dig2),
    .dig3      (dig3),
    .dig4      (dig4),
    .dig5      (dig5),
    .dig6      (dig6),
    .digit_cnt (digit_cnt),
    .full      (full),
    .submit    (submit),
    .err       (err),
    .timeout   (timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic model_reset();
    q.delete();
    pending = 0;
    idle    = 0;
    exp_sub = 0;
    exp_err = 0;
    exp_to  = 0;
  endtask

  task automatic model_step(input logic v, input logic [3:0] c);
    exp_sub = 0;
    exp_err = 0;
    exp_to  = 0;
    if (pending) begin
      q.delete();
      pending = 0;
      idle    = 0;
    end else if (v && c <= 4'hC) begin
      idle = 0;
      if (c <= 4'd9) begin
        if (q.size() < 6) q.push_back(int'(c));
        else exp_err = 1;
      end else if (c == 4'hA) begin
        if (q.size() > 0) void'(q.pop_back());
      end else if (c == 4'hC) begin
        q.delete();
      end else begin
        if (q.size() == 6) begin
          exp_sub = 1;
          pending = 1;
        end else begin
          exp_err = 1;
        end
      end
    end else if (q.size() > 0) begin
      if (idle == TMO - 1) begin
        q.delete();
        exp_to = 1;
        idle   = 0;
      end else begin
        idle++;
      end
    end
  endtask

  task automatic check(input string tag);
    logic [23:0] exp_dig;
    logic [23:0] got_dig;
    logic [2:0]  exp_p;
    logic [2:0]  got_p;
    exp_dig = '0;
    for (int i = 0; i < 6; i++) begin
      exp_dig = {exp_dig[19:0], (i < q.size()) ? 4'(q[i]) : 4'd0};
    end
    got_dig = {dig1, dig2, dig3, dig4, dig5, dig6};
    exp_p   = {exp_sub, exp_err, exp_to};
    got_p   = {submit, err, timeout};

    checks++;
    assert (got_dig === exp_dig) else begin
      errors++;
      $error("FAIL %s digits: got %h expected %h", tag, got_dig, exp_dig);
    end
    checks++;
    assert (digit_cnt === 3'(q.size())) else begin
      errors++;
      $error("FAIL %s digit_cnt: got %0d expected %0d", tag, digit_cnt, q.size());
    end
    checks++;
    assert (full === (q.size() == 6)) else begin
      errors++;
      $error("FAIL %s full: got %b expected %b", tag, full, q.size() == 6);
    end
    checks++;
    assert (got_p === exp_p) else begin
      errors++;
      $error("FAIL %s submit/err/timeout: got %b expected %b", tag, got_p, exp_p);
    end
  endtask

  task automatic expect_val(input string tag, input int got, input int want);
    checks++;
    assert (got === want) else begin
      errors++;
      $error("FAIL %s: got %0d expected %0d", tag, got, want);
    end
  endtask

  task automatic drive(input logic v, input logic [3:0] c, input string tag);
    key_valid = v;
    key_code  = c;
    @(posedge clk);
    model_step(v, c);
    #1;
    key_valid = 1'b0;
    check(tag);
    if (v) begin
      $display("[%0t] %s key=%h -> cnt=%0d sub=%0b err=%0b to=%0b",
               $time, tag, c, digit_cnt, submit, err, timeout);
    end
  endtask

  task automatic idle_cycles(input int n, input string tag);
    for (int i = 0; i < n; i++) begin
      drive(1'b0, 4'($urandom), tag);
    end
  endtask

  initial begin
    logic [3:0] code;
    int r;

    clr_n     = 1'b0;
    key_valid = 1'b0;
    key_code  = 4'h0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check("reset");
    clr_n = 1'b1;

    // 1: six digits then enter
    for (int i = 1; i <= 6; i++) drive(1'b1, 4'(i), "t1_digit");
    expect_val("t1_full", int'(full), 1);
    drive(1'b1, 4'hB, "t1_enter");
    expect_val("t1_submit", int'(submit), 1);
    expect_val("t1_dig_during_submit", int'({dig1, dig2, dig3, dig4, dig5, dig6}), 24'h123456);
    idle_cycles(1, "t1_after");
    expect_val("t1_cnt_after", int'(digit_cnt), 0);

    // 2: 7,8,9,BKSP,4,enter
    drive(1'b1, 4'h7, "t2"); drive(1'b1, 4'h8, "t2"); drive(1'b1, 4'h9, "t2");
    drive(1'b1, 4'hA, "t2_bksp"); drive(1'b1, 4'h4, "t2");
    drive(1'b1, 4'hB, "t2_enter");
    expect_val("t2_err", int'(err), 1);
    expect_val("t2_digits", int'({dig1, dig2, dig3}), 12'h784);
    drive(1'b1, 4'hC, "t2_clear");

    // 3: digit while full
    for (int i = 0; i < 6; i++) drive(1'b1, 4'(9 - i), "t3_digit");
    drive(1'b1, 4'h9, "t3_overflow");
    expect_val("t3_err", int'(err), 1);
    expect_val("t3_dig6", int'(dig6), 4);
    expect_val("t3_full", int'(full), 1);
    drive(1'b1, 4'hC, "t3_clear");

    // 4: timeout after TMO idle cycles
    drive(1'b1, 4'h5, "t4_key");
    idle_cycles(TMO - 1, "t4_idle");
    drive(1'b0, 4'h0, "t4_term");
    expect_val("t4_timeout", int'(timeout), 1);
    expect_val("t4_dig1", int'(dig1), 0);

    // 5: key on the terminal cycle wins
    drive(1'b1, 4'h5, "t5_key");
    idle_cycles(TMO - 1, "t5_idle");
    drive(1'b1, 4'h6, "t5_term_key");
    expect_val("t5_no_timeout", int'(timeout), 0);
    expect_val("t5_cnt", int'(digit_cnt), 2);
    idle_cycles(TMO - 1, "t5_idle2");
    drive(1'b0, 4'h0, "t5_term2");
    expect_val("t5_timeout_restarted", int'(timeout), 1);

    // D-F are ignored and do not restart the timer
    drive(1'b1, 4'h3, "t6_key");
    idle_cycles(8, "t6_idle");
    drive(1'b1, 4'hD, "t6_ignored"); drive(1'b1, 4'hE, "t6_ignored"); drive(1'b1, 4'hF, "t6_ignored");
    idle_cycles(4, "t6_idle");
    drive(1'b0, 4'h0, "t6_term");
    expect_val("t6_timeout_ignores_def", int'(timeout), 1);

    // 6: asynchronous reset between edges
    drive(1'b1, 4'h1, "t7"); drive(1'b1, 4'h2, "t7"); drive(1'b1, 4'h3, "t7");
    #3 clr_n = 1'b0;
    #1;
    model_reset();
    check("t7_async_reset");
    expect_val("t7_cnt", int'(digit_cnt), 0);
    #2 clr_n = 1'b1;

    // Randomized traffic
    for (int n = 0; n < 300; n++) begin
      if (n % 60 == 59) idle_cycles(TMO + 2, "rnd_gap");
      if ($urandom_range(0, 2) == 0) begin
        drive(1'b0, 4'($urandom), "rnd_idle");
      end else begin
        r = $urandom_range(0, 19);
        if (r < 14)       code = 4'(r % 10);
        else if (r == 14) code = 4'hA;
        else if (r == 15) code = 4'hB;
        else if (r == 16) code = 4'hC;
        else              code = 4'($urandom_range(13, 15));
        drive(1'b1, code, "rnd_key");
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
